// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared definitions for the buffered UART peripheral.
//   - register select decoded from addr[3:2]
//   - STATUS / CTRL / IRQ bit positions
//   - 8-bit saturating count type and the helper that produces it
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_IRQ    = 2'd3
  } reg_sel_e;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_BUSY  = 5;

  localparam int CTRL_LOOPBACK = 16;
  localparam int CTRL_IE_RX    = 17;
  localparam int CTRL_IE_TX    = 18;
  localparam int CTRL_IE_ERR   = 19;

  localparam int IRQ_FRAME_ERR = 0;
  localparam int IRQ_OVERRUN   = 1;
  localparam int IRQ_RX_OVF    = 2;
  localparam int IRQ_TX_OVF    = 3;

  typedef logic [7:0] count8_t;

  // A 256-deep FIFO can hold 256 entries, which does not fit in 8 bits.
  function automatic count8_t sat_count8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/axi_uart.sv
// axi_uart: 8N1 serial engine with 8-bit AXI-stream sides.
//   clk, rst (sync, active high)
//   prescale           : bit time = prescale*8 clocks
//   s_axis_*           : bytes to transmit (accepted only while idle)
//   m_axis_*           : received bytes (one-cycle tvalid per byte)
//   rxd / txd          : serial lines (idle high)
//   tx_busy, rx_busy   : frame in progress
//   rx_overrun_error   : pulse, byte received while previous one not taken
//   rx_frame_error     : pulse, stop bit sampled low
module axi_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_busy,
  output logic        rx_busy,
  output logic        rx_overrun_error,
  output logic        rx_frame_error
);

  logic [18:0] bit_len, half_len;
  assign bit_len  = {prescale, 3'b000};
  assign half_len = {1'b0, prescale, 2'b00};

  logic        tx_busy_q, tx_busy_d, txd_q, txd_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic [18:0] tx_timer_q, tx_timer_d;

  logic        rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d;
  logic        rx_busy_q, rx_busy_d;
  logic [7:0]  rx_shift_q, rx_shift_d, m_tdata_q, m_tdata_d;
  logic [3:0]  rx_bits_q, rx_bits_d;
  logic [18:0] rx_timer_q, rx_timer_d;
  logic        m_tvalid_q, m_tvalid_d, overrun_q, overrun_d, frame_q, frame_d;

  assign s_axis_tready    = !tx_busy_q;
  assign txd              = txd_q;
  assign tx_busy          = tx_busy_q;
  assign rx_busy          = rx_busy_q;
  assign m_axis_tdata     = m_tdata_q;
  assign m_axis_tvalid    = m_tvalid_q;
  assign rx_overrun_error = overrun_q;
  assign rx_frame_error   = frame_q;

  // Transmitter: start bit driven on accept, then 8 data bits and a stop bit
  // shifted out of {1, data}; the shift fills with 1 so the stop bit falls out.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    txd_d      = txd_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_timer_d = tx_timer_q;
    if (!tx_busy_q) begin
      if (s_axis_tvalid) begin
        tx_busy_d  = 1'b1;
        txd_d      = 1'b0;
        tx_shift_d = {1'b1, s_axis_tdata};
        tx_bits_d  = 4'd9;
        tx_timer_d = bit_len - 19'd1;
      end
    end else if (tx_timer_q != 19'd0) begin
      tx_timer_d = tx_timer_q - 19'd1;
    end else if (tx_bits_q == 4'd0) begin
      tx_busy_d = 1'b0;
    end else begin
      txd_d      = tx_shift_q[0];
      tx_shift_d = {1'b1, tx_shift_q[8:1]};
      tx_bits_d  = tx_bits_q - 4'd1;
      tx_timer_d = bit_len - 19'd1;
    end
  end

  // Receiver: after a falling edge wait half a bit, confirm the start bit,
  // then sample 8 data bits and the stop bit at bit centres.
  // rx_bits counts remaining samples: 10 = start, 9..2 = data, 1 = stop.
  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rx_busy_d  = rx_busy_q;
    rx_shift_d = rx_shift_q;
    rx_bits_d  = rx_bits_q;
    rx_timer_d = rx_timer_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q && !m_axis_tready;
    overrun_d  = 1'b0;
    frame_d    = 1'b0;
    if (!rx_busy_q) begin
      if (!rxd_s2_q) begin
        rx_busy_d  = 1'b1;
        rx_bits_d  = 4'd10;
        rx_timer_d = half_len - 19'd1;
      end
    end else if (rx_timer_q != 19'd0) begin
      rx_timer_d = rx_timer_q - 19'd1;
    end else begin
      rx_timer_d = bit_len - 19'd1;
      rx_bits_d  = rx_bits_q - 4'd1;
      if (rx_bits_q == 4'd10) begin
        if (rxd_s2_q) rx_busy_d = 1'b0;   // glitch, not a start bit
      end else if (rx_bits_q != 4'd1) begin
        rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
      end else begin
        rx_busy_d = 1'b0;
        if (rxd_s2_q) begin
          overrun_d  = m_tvalid_q && !m_axis_tready;
          m_tdata_d  = rx_shift_q;
          m_tvalid_d = 1'b1;
        end else begin
          frame_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_timer_q <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_shift_q <= '0;
      rx_bits_q  <= '0;
      rx_timer_q <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      overrun_q  <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      txd_q      <= txd_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_timer_q <= tx_timer_d;
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rx_busy_q  <= rx_busy_d;
      rx_shift_q <= rx_shift_d;
      rx_bits_q  <= rx_bits_d;
      rx_timer_q <= rx_timer_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      overrun_q  <= overrun_d;
      frame_q    <= frame_d;
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with wrap-bit pointers.
//   clk, reset_n (sync, active low)
//   push_i/push_data_i : write side; accepted when not full or when a pop
//                        happens in the same cycle
//   pop_i/pop_data_o   : read side; pop_data_o shows the current head
//   full_o, empty_o, count_o (0..DEPTH)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot the push is about to reuse, so full+pop still accepts.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_fifo_peripheral.sv
// uart_fifo_peripheral: memory-mapped UART with TX/RX FIFOs, sticky error
// flags and a registered level interrupt.
//   clk, reset_n (sync, active low; also holds axi_uart in reset)
//   data_req_i, slave_data_{addr,we,be,wdata}_i : bus request
//   slave_data_gnt_o, slave_data_rvalid_o        : one cycle after each request
//   slave_data_rdata_o                           : updated on reads only
//   rxd_uart / txd_uart                          : serial lines
//   irq_o                                        : level interrupt
// Register map (addr[3:2]): DATA, STATUS (RO), CTRL (RW), IRQ (W1C).
// Optional feature macro: UART_LOOPBACK_EN -- enables CTRL[16] internal
// loopback (txd fed to the receiver, txd_uart held idle).
module uart_fifo_peripheral
  import uart_fifo_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] slave_data_addr_i,
  input  logic                  slave_data_we_i,
  input  logic [3:0]            slave_data_be_i,
  input  logic [DATA_WIDTH-1:0] slave_data_wdata_i,
  output logic [DATA_WIDTH-1:0] slave_data_rdata_o,
  output logic                  slave_data_rvalid_o,
  output logic                  slave_data_gnt_o,
  input  logic                  data_req_i,
  input  logic                  rxd_uart,
  output logic                  txd_uart,
  output logic                  irq_o
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  logic        gnt_q, gnt_d, rvalid_q, rvalid_d, irq_o_q, irq_o_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] prescale_q, prescale_d;
  logic        ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d, ie_err_q, ie_err_d;
  logic [3:0]  irq_sts_q, irq_sts_d, irq_set, irq_clr;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [TAW:0]  tx_count;
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head, rx_data;
  logic [RAW:0]  rx_count;

  logic uart_txd, uart_rxd, uart_tx_busy, uart_rx_busy, uart_tready;
  logic uart_rx_valid, uart_overrun, uart_frame_err, loopback_bit;
  logic [31:0] status_word, ctrl_word;
  reg_sel_e    sel;

  assign sel                 = reg_sel_e'(slave_data_addr_i[3:2]);
  assign tx_pop              = !tx_empty && uart_tready;
  assign slave_data_gnt_o    = gnt_q;
  assign slave_data_rvalid_o = rvalid_q;
  assign slave_data_rdata_o  = rdata_q;
  assign irq_o               = irq_o_q;

`ifdef UART_LOOPBACK_EN
  logic loopback_q, loopback_d;
  logic unused_bits;
  assign loopback_bit = loopback_q;
  assign uart_rxd     = loopback_q ? uart_txd : rxd_uart;
  assign txd_uart     = loopback_q ? 1'b1 : uart_txd;
  assign unused_bits  = ^{slave_data_addr_i[ADDR_WIDTH-1:4], slave_data_addr_i[1:0],
                          slave_data_be_i[3], slave_data_wdata_i[31:20]};

  always_comb begin
    loopback_d = loopback_q;
    if (data_req_i && slave_data_we_i && sel == REG_CTRL && slave_data_be_i[2])
      loopback_d = slave_data_wdata_i[CTRL_LOOPBACK];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) loopback_q <= 1'b0;
    else          loopback_q <= loopback_d;
  end
`else
  logic unused_bits;
  assign loopback_bit = 1'b0;
  assign uart_rxd     = rxd_uart;
  assign txd_uart     = uart_txd;
  assign unused_bits  = ^{slave_data_addr_i[ADDR_WIDTH-1:4], slave_data_addr_i[1:0],
                          slave_data_be_i[3], slave_data_wdata_i[31:20],
                          slave_data_wdata_i[CTRL_LOOPBACK]};
`endif

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(tx_push), .push_data_i(slave_data_wdata_i[7:0]),
    .pop_i(tx_pop), .pop_data_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(uart_rx_valid), .push_data_i(rx_data),
    .pop_i(rx_pop), .pop_data_o(rx_head),
    .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  axi_uart u_uart (
    .clk(clk), .rst(!reset_n), .prescale(prescale_q),
    .s_axis_tdata(tx_head), .s_axis_tvalid(!tx_empty), .s_axis_tready(uart_tready),
    .m_axis_tdata(rx_data), .m_axis_tvalid(uart_rx_valid), .m_axis_tready(1'b1),
    .rxd(uart_rxd), .txd(uart_txd),
    .tx_busy(uart_tx_busy), .rx_busy(uart_rx_busy),
    .rx_overrun_error(uart_overrun), .rx_frame_error(uart_frame_err)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_TX_BUSY]  = uart_tx_busy;
    status_word[ST_RX_BUSY]  = uart_rx_busy;
    status_word[15:8]        = sat_count8(9'(rx_count));
    status_word[23:16]       = sat_count8(9'(tx_count));
    ctrl_word = {12'b0, ie_err_q, ie_tx_q, ie_rx_q, loopback_bit, prescale_q};
  end

  always_comb begin
    gnt_d      = data_req_i;
    rvalid_d   = data_req_i;
    rdata_d    = rdata_q;
    prescale_d = prescale_q;
    ie_rx_d    = ie_rx_q;
    ie_tx_d    = ie_tx_q;
    ie_err_d   = ie_err_q;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    irq_clr    = 4'b0;
    if (data_req_i && slave_data_we_i) begin
      case (sel)
        REG_DATA: tx_push = slave_data_be_i[0];
        REG_CTRL: begin
          if (slave_data_be_i[0]) prescale_d[7:0]  = slave_data_wdata_i[7:0];
          if (slave_data_be_i[1]) prescale_d[15:8] = slave_data_wdata_i[15:8];
          if (slave_data_be_i[2]) begin
            ie_rx_d  = slave_data_wdata_i[CTRL_IE_RX];
            ie_tx_d  = slave_data_wdata_i[CTRL_IE_TX];
            ie_err_d = slave_data_wdata_i[CTRL_IE_ERR];
          end
        end
        REG_IRQ:  if (slave_data_be_i[0]) irq_clr = slave_data_wdata_i[3:0];
        default:  ;
      endcase
    end else if (data_req_i) begin
      case (sel)
        REG_DATA: begin
          rdata_d = rx_empty ? 32'b0 : {23'b0, 1'b1, rx_head};
          rx_pop  = !rx_empty;
        end
        REG_STATUS: rdata_d = status_word;
        REG_CTRL:   rdata_d = ctrl_word;
        default:    rdata_d = {28'b0, irq_sts_q};
      endcase
    end

    irq_set = '0;
    irq_set[IRQ_FRAME_ERR] = uart_frame_err;
    irq_set[IRQ_OVERRUN]   = uart_overrun;
    irq_set[IRQ_RX_OVF]    = uart_rx_valid && rx_full && !rx_pop;
    irq_set[IRQ_TX_OVF]    = tx_push && tx_full && !tx_pop;
    // A new event in the same cycle as its clear must survive.
    irq_sts_d = (irq_sts_q & ~irq_clr) | irq_set;
    irq_o_d   = (ie_rx_q && !rx_empty) || (ie_tx_q && tx_empty) || (ie_err_q && |irq_sts_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      prescale_q <= PRESCALE_RST;
      ie_rx_q    <= 1'b0;
      ie_tx_q    <= 1'b0;
      ie_err_q   <= 1'b0;
      irq_sts_q  <= '0;
      irq_o_q    <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      prescale_q <= prescale_d;
      ie_rx_q    <= ie_rx_d;
      ie_tx_q    <= ie_tx_d;
      ie_err_q   <= ie_err_d;
      irq_sts_q  <= irq_sts_d;
      irq_o_q    <= irq_o_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_peripheral.sv
// Bench for uart_fifo_peripheral with 4-deep FIFOs and prescale 1
// (8 clocks per serial bit). Transmitted bytes are queued when written and
// checked by a serial monitor; received bytes are queued when driven on rxd
// and checked on DATA reads.
module tb_uart_fifo_peripheral;

  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam logic [9:0] A_DATA = 10'h000, A_STATUS = 10'h004, A_CTRL = 10'h008, A_IRQ = 10'h00C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, gnt;
  logic        req = 1'b0;
  logic        rxd = 1'b1;
  logic        txd, irq;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  tx_mon_byte;
  logic [31:0] rv;

  always #5 clk = ~clk;

  uart_fifo_peripheral #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .PRESCALE_RST(16'd1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .slave_data_addr_i(addr), .slave_data_we_i(we), .slave_data_be_i(be),
    .slave_data_wdata_i(wdata), .slave_data_rdata_o(rdata),
    .slave_data_rvalid_o(rvalid), .slave_data_gnt_o(gnt),
    .data_req_i(req), .rxd_uart(rxd), .txd_uart(txd), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("gnt_wr", 32'(gnt), 32'd1);
    $display("wr addr=%03h data=%08h be=%h", a, d, b);
  endtask

  task automatic bus_rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    chk("rvalid_rd", 32'(rvalid), 32'd1);
    d = rdata;
    $display("rd addr=%03h data=%08h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b);
    @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    $display("rx frame sent %02h", b);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_drain", 32'(tx_exp.size()), 32'd0);
    repeat (16) @(negedge clk);
  endtask

  // Serial monitor: samples txd at bit centres and pops the scoreboard.
  initial begin
    forever begin
      @(negedge txd);
      repeat (4) @(posedge clk);
      #1;
      if (txd == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(posedge clk);
          #1;
          tx_mon_byte[i] = txd;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("tx_stop", 32'(txd), 32'd1);
        if (tx_exp.size() == 0) chk("tx_unexpected", 32'(tx_exp.size()), 32'd1);
        else chk("tx_byte", 32'(tx_mon_byte), 32'(tx_exp.pop_front()));
        $display("tx frame seen %02h", tx_mon_byte);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_txd", 32'(txd), 32'd1);
    rd_chk("rst_status", A_STATUS, 32'h0000_0005);
    rd_chk("rst_ctrl", A_CTRL, 32'h0000_0001);
    rd_chk("rst_irqreg", A_IRQ, 32'h0);

    // CTRL byte enables and unimplemented bits
    bus_wr(A_CTRL, 32'hFFF0_FF05, 4'b0001);
    rd_chk("ctrl_be0", A_CTRL, 32'h0000_0005);
    bus_wr(A_CTRL, 32'hFFF0_0001, 4'hF);
    rd_chk("ctrl_hi0", A_CTRL, 32'h0000_0001);

    // Two bytes out; the first is taken by the idle UART straight away
    tx_exp.push_back(8'h55);
    bus_wr(A_DATA, 32'h0000_0055, 4'h1);
    tx_exp.push_back(8'hA3);
    bus_wr(A_DATA, 32'h0000_00A3, 4'h1);
    chk("rdata_hold", rdata, 32'h0000_0001);
    rd_chk("tx2_status", A_STATUS, 32'h0001_0014);
    wait_tx_drain(400);
    rd_chk("tx2_done", A_STATUS, 32'h0000_0005);

    // TX overflow: UART busy, then TXD+1 writes -> last one dropped
    tx_exp.push_back(8'h10);
    bus_wr(A_DATA, 32'h0000_0010, 4'h1);
    repeat (3) @(negedge clk);
    for (int i = 0; i <= TXD; i++) begin
      b = 8'h20 + 8'(i * 7);
      if (i < TXD) tx_exp.push_back(b);
      bus_wr(A_DATA, {24'h0, b}, 4'h1);
    end
    rd_chk("txovf_status", A_STATUS, 32'h0004_0016);
    rd_chk("txovf_irq", A_IRQ, 32'h0000_0008);
    bus_wr(A_CTRL, 32'h0008_0001, 4'hF);
    repeat (2) @(negedge clk);
    chk("ie_err_irq", 32'(irq), 32'd1);
    bus_wr(A_IRQ, 32'h0000_0008, 4'hF);
    repeat (2) @(negedge clk);
    chk("ie_err_clr", 32'(irq), 32'd0);
    rd_chk("txovf_w1c", A_IRQ, 32'h0);
    bus_wr(A_CTRL, 32'h0000_0001, 4'hF);
    wait_tx_drain(1000);

    // RX overflow: RXD+1 frames, no reads
    for (int i = 0; i <= RXD; i++) begin
      b = 8'h5A ^ 8'(i * 37);
      if (i < RXD) rx_exp.push_back(b);
      send_frame(b);
    end
    repeat (4) @(negedge clk);
    rd_chk("rxovf_status", A_STATUS, 32'h0000_0409);
    rd_chk("rxovf_irq", A_IRQ, 32'h0000_0004);
    while (rx_exp.size() != 0) begin
      bus_rd(A_DATA, rv);
      chk("rx_data", rv, {23'b0, 1'b1, rx_exp.pop_front()});
    end
    rd_chk("rx_empty_rd", A_DATA, 32'h0);
    rd_chk("rx_drained", A_STATUS, 32'h0000_0005);
    bus_wr(A_IRQ, 32'h0000_0004, 4'hF);
    rd_chk("rxovf_w1c", A_IRQ, 32'h0);

    // RX not-empty interrupt
    bus_wr(A_CTRL, 32'h0002_0001, 4'hF);
    repeat (2) @(negedge clk);
    chk("ie_rx_idle", 32'(irq), 32'd0);
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C);
    n = 0;
    while (irq != 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ie_rx_rise", 32'(irq), 32'd1);
    bus_rd(A_DATA, rv);
    chk("ie_rx_data", rv, {23'b0, 1'b1, rx_exp.pop_front()});
    chk("ie_rx_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("ie_rx_clear", 32'(irq), 32'd0);

    // TX empty interrupt
    bus_wr(A_CTRL, 32'h0004_0001, 4'hF);
    repeat (2) @(negedge clk);
    chk("ie_tx_irq", 32'(irq), 32'd1);
    bus_wr(A_CTRL, 32'h0000_0001, 4'hF);
    repeat (2) @(negedge clk);
    chk("ie_tx_off", 32'(irq), 32'd0);

`ifdef UART_LOOPBACK_EN
    // Loopback: byte comes back into RX, txd pin stays idle
    bus_wr(A_CTRL, 32'h0001_0001, 4'hF);
    rd_chk("lb_ctrl", A_CTRL, 32'h0001_0001);
    rx_exp.push_back(8'h7E);
    bus_wr(A_DATA, 32'h0000_007E, 4'h1);
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) n++;
    end
    chk("lb_txd_idle", 32'(n), 32'd0);
    bus_rd(A_DATA, rv);
    chk("lb_data", rv, {23'b0, 1'b1, rx_exp.pop_front()});
    bus_wr(A_CTRL, 32'h0000_0001, 4'hF);
`else
    // Without the loopback feature CTRL[16] is not stored
    bus_wr(A_CTRL, 32'h0001_0001, 4'hF);
    rd_chk("lb_absent", A_CTRL, 32'h0000_0001);
`endif

    repeat (20) @(negedge clk);
    chk("tx_queue_end", 32'(tx_exp.size()), 32'd0);
    chk("rx_queue_end", 32'(rx_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
